instr_fetch_unit: RTL and testbench

Fetch/issue sequencer that feeds 16-bit instruction words to the control-unit decoder, and consumes the decoder's branch output to choose the next PC. It holds the program counter, reads the synchronous instruction memory (1-cycle read latency), and presents one instruction to the decoder per issue slot. It also handles stalls, taken branches and a halt opcode. It sits between the IM and the decoder/datapath.

---
 rtl/instr_fetch_unit.sv | 110 +++++++++++
 tb/tb_instr_fetch_unit.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : instr_fetch_unit                                             |
// | Description : Fetch/issue sequencer between the instruction memory and     |
// |               the decoder: holds the PC, reads the IM and issues words.    |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
    parameter int                ADDR_W   = 8,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              stall,
    output logic              im_en,
    output logic [ADDR_W-1:0] im_addr,
    input  logic [15:0]       im_rdata,
    output logic [15:0]       instr,
    output logic              instr_valid,
    input  logic              branch,
    input  logic              cond_true,
    output logic [ADDR_W-1:0] pc,
    output logic              halted,
    output logic [15:0]       retired
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_WAIT  = 3'd2;
    localparam logic [2:0] S_EXEC  = 3'd3;
    localparam logic [2:0] S_HALT  = 3'd4;

    localparam logic [4:0]        C_HALT_OP = 5'b11111;
    localparam logic [ADDR_W-1:0] C_PC_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [15:0]       C_RET_MAX = 16'hFFFF;

    logic [2:0]        r_state,   w_state_nxt;
    logic [ADDR_W-1:0] r_pc,      w_pc_nxt;
    logic [15:0]       r_instr,   w_instr_nxt;
    logic [15:0]       r_retired, w_retired_nxt;
    logic              w_is_halt;

    assign w_is_halt = (r_instr[15:11] == C_HALT_OP);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_instr   <= 16'h0000;
            r_retired <= 16'h0000;
        end else begin
            r_state   <= w_state_nxt;
            r_pc      <= w_pc_nxt;
            r_instr   <= w_instr_nxt;
            r_retired <= w_retired_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_pc_nxt      = r_pc;
        w_instr_nxt   = r_instr;
        w_retired_nxt = r_retired;
        im_en         = 1'b0;
        im_addr       = '0;
        instr_valid   = 1'b0;
        halted        = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) w_state_nxt = S_FETCH;
            end
            S_FETCH: begin
                im_en       = 1'b1;
                im_addr     = r_pc;
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                w_instr_nxt = im_rdata;
                w_state_nxt = S_EXEC;
            end
            S_EXEC: begin
                instr_valid = 1'b1;
                if (!stall) begin
                    if (r_retired != C_RET_MAX) w_retired_nxt = r_retired + 16'd1;
                    // Halt outranks a simultaneous branch: PC stays on the halt word.
                    if (w_is_halt) begin
                        w_state_nxt = S_HALT;
                    end else begin
                        if (branch && cond_true) w_pc_nxt = r_instr[ADDR_W-1:0];
                        else                     w_pc_nxt = r_pc + C_PC_ONE;
                        w_state_nxt = S_FETCH;
                    end
                end
            end
            S_HALT: begin
                halted = 1'b1;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    assign instr   = r_instr;
    assign pc      = r_pc;
    assign retired = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_instr_fetch_unit                                          |
// | Description : Self-checking bench for instr_fetch_unit with an IM model.   |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst, start, stall, branch, cond_true;
    logic        im_en, instr_valid, halted;
    logic [7:0]  im_addr, pc;
    logic [15:0] im_rdata, instr, retired;

    logic [15:0] mem [256];

    int          checks = 0;
    int          errors = 0;

    // Architectural model state: next PC to execute and retire count
    logic [7:0]  pc_m;
    int          ret_m;

    instr_fetch_unit #(.ADDR_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst(rst), .start(start), .stall(stall),
        .im_en(im_en), .im_addr(im_addr), .im_rdata(im_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .branch(branch), .cond_true(cond_true),
        .pc(pc), .halted(halted), .retired(retired)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (im_en) im_rdata <= mem[im_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; stall = 1'b0; branch = 1'b0; cond_true = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        pc_m  = 8'h00;
        ret_m = 0;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Executes one instruction from its FETCH cycle onward against the model
    task automatic run_instr(input bit br, input bit ct, input int nst);
        logic [15:0] w;
        w = mem[pc_m];
        checks++; if (im_en !== 1'b1 || im_addr !== pc_m) begin errors++;
            $display("FAIL fetch got im_en=%0b im_addr=%h want 1/%h", im_en, im_addr, pc_m); end
        checks++; if (instr_valid !== 1'b0) begin errors++;
            $display("FAIL fetch_valid got %0b want 0", instr_valid); end
        tick();
        checks++; if (im_en !== 1'b0 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL wait got im_en=%0b valid=%0b want 0/0", im_en, instr_valid); end
        tick();
        checks++; if (instr_valid !== 1'b1 || instr !== w || pc !== pc_m) begin errors++;
            $display("FAIL exec got valid=%0b instr=%h pc=%h want 1/%h/%h", instr_valid, instr, pc, w, pc_m); end
        checks++; if (retired !== 16'(ret_m)) begin errors++;
            $display("FAIL exec_retired got %0d want %0d", retired, ret_m); end
        branch = br; cond_true = ct; stall = (nst > 0);
        for (int i = 0; i < nst; i++) begin
            tick();
            if (i == nst - 1) stall = 1'b0;
            checks++; if (instr_valid !== 1'b1 || instr !== w || pc !== pc_m || retired !== 16'(ret_m)) begin errors++;
                $display("FAIL stall got valid=%0b instr=%h pc=%h ret=%0d want 1/%h/%h/%0d",
                         instr_valid, instr, pc, retired, w, pc_m, ret_m); end
        end
        tick();
        branch = 1'b0; cond_true = 1'b0;
        if (ret_m < 65535) ret_m++;
        checks++; if (retired !== 16'(ret_m)) begin errors++;
            $display("FAIL retire_count got %0d want %0d", retired, ret_m); end
        if (w[15:11] == 5'b11111) begin
            checks++; if (halted !== 1'b1 || im_en !== 1'b0 || instr_valid !== 1'b0 || pc !== pc_m) begin errors++;
                $display("FAIL halt got halted=%0b im_en=%0b valid=%0b pc=%h want 1/0/0/%h",
                         halted, im_en, instr_valid, pc, pc_m); end
        end else begin
            pc_m = (br && ct) ? w[7:0] : pc_m + 8'd1;
            checks++; if (halted !== 1'b0 || pc !== pc_m) begin errors++;
                $display("FAIL next_pc got halted=%0b pc=%h want 0/%h", halted, pc, pc_m); end
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 8'h00 || instr !== 16'h0 || instr_valid !== 1'b0) begin errors++;
            $display("FAIL reset_regs got pc=%h instr=%h valid=%0b want 00/0000/0", pc, instr, instr_valid); end
        checks++; if (im_en !== 1'b0 || im_addr !== 8'h00 || halted !== 1'b0 || retired !== 16'h0) begin errors++;
            $display("FAIL reset_out got im_en=%0b addr=%h halted=%0b ret=%0d want 0/00/0/0",
                     im_en, im_addr, halted, retired); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (im_en !== 1'b0 || instr_valid !== 1'b0) begin errors++;
                $display("FAIL idle got im_en=%0b valid=%0b want 0/0", im_en, instr_valid); end
        end
    endtask

    task automatic test_sequential();
        do_reset();
        mem[0] = 16'h0040; mem[1] = 16'h0080; mem[2] = 16'h00C0; mem[3] = 16'h0100;
        do_start();
        for (int i = 0; i < 4; i++) run_instr(1'b0, 1'b0, 0);
        checks++; if (retired !== 16'd4) begin errors++;
            $display("FAIL seq_retired got %0d want 4", retired); end
    endtask

    task automatic test_branch(input bit ct);
        do_reset();
        mem[0] = 16'h0040; mem[1] = 16'h0080; mem[2] = 16'h8005;
        mem[3] = 16'h0011; mem[5] = 16'h0022;
        do_start();
        run_instr(1'b0, 1'b0, 0);
        run_instr(1'b0, 1'b0, 0);
        run_instr(1'b1, ct, 0);
        checks++; if (im_addr !== (ct ? 8'h05 : 8'h03)) begin errors++;
            $display("FAIL branch_addr ct=%0b got %h want %h", ct, im_addr, ct ? 8'h05 : 8'h03); end
        run_instr(1'b0, 1'b0, 0);
    endtask

    task automatic test_stall();
        do_reset();
        mem[0] = 16'h0040; mem[1] = 16'h0080; mem[2] = 16'h00C0;
        do_start();
        run_instr(1'b0, 1'b0, 0);
        run_instr(1'b0, 1'b0, 4);
        checks++; if (im_addr !== 8'h02) begin errors++;
            $display("FAIL stall_next got %h want 02", im_addr); end
        run_instr(1'b0, 1'b0, 0);
    endtask

    task automatic test_wrap_halt();
        do_reset();
        mem[0] = 16'h80FE; mem[8'hFE] = 16'h0040; mem[8'hFF] = 16'h0040;
        do_start();
        run_instr(1'b1, 1'b1, 0);
        mem[0] = 16'hF800;
        run_instr(1'b0, 1'b0, 0);
        run_instr(1'b0, 1'b0, 0);
        checks++; if (pc !== 8'h00) begin errors++;
            $display("FAIL wrap_pc got %h want 00", pc); end
        run_instr(1'b0, 1'b0, 0);
        for (int i = 0; i < 12; i++) begin
            start = (i % 3 == 0);
            tick();
            checks++; if (halted !== 1'b1 || im_en !== 1'b0 || instr_valid !== 1'b0) begin errors++;
                $display("FAIL halt_hold got halted=%0b im_en=%0b valid=%0b want 1/0/0", halted, im_en, instr_valid); end
        end
        start = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_reset();
        mem[0] = 16'h0040; mem[1] = 16'h0080;
        do_start();
        run_instr(1'b0, 1'b0, 0);
        tick();
        tick();
        checks++; if (instr_valid !== 1'b1) begin errors++;
            $display("FAIL rmid_exec got %0b want 1", instr_valid); end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++; if (pc !== 8'h00 || instr_valid !== 1'b0 || retired !== 16'd0 || im_en !== 1'b0) begin errors++;
            $display("FAIL rmid got pc=%h valid=%0b ret=%0d im_en=%0b want 00/0/0/0", pc, instr_valid, retired, im_en); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (im_en !== 1'b0) begin errors++;
                $display("FAIL rmid_idle got im_en=%0b want 0", im_en); end
        end
        pc_m = 8'h00; ret_m = 0;
        do_start();
        run_instr(1'b0, 1'b0, 0);
    endtask

    task automatic test_halt_branch();
        do_reset();
        mem[0] = 16'hF805;
        do_start();
        run_instr(1'b1, 1'b1, 0);
        checks++; if (pc !== 8'h00 || retired !== 16'd1 || halted !== 1'b1) begin errors++;
            $display("FAIL halt_branch got pc=%h ret=%0d halted=%0b want 00/1/1", pc, retired, halted); end
    endtask

    task automatic test_random();
        for (int r = 0; r < 4; r++) begin
            do_reset();
            for (int a = 0; a < 256; a++) begin
                mem[a] = 16'($urandom);
                if (mem[a][15:11] == 5'b11111 && ($urandom_range(0, 3) != 0)) mem[a][15] = 1'b0;
            end
            do_start();
            for (int n = 0; n < 40; n++) begin
                logic [15:0] w;
                w = mem[pc_m];
                run_instr(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
                if (w[15:11] == 5'b11111) break;
            end
        end
    endtask

    initial begin
        im_rdata = 16'h0;
        for (int a = 0; a < 256; a++) mem[a] = 16'h0;
        test_reset();
        test_sequential();
        test_branch(1'b1);
        test_branch(1'b0);
        test_stall();
        test_wrap_halt();
        test_reset_mid();
        test_halt_branch();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
